// File: rtl/filtro_conv3x3.sv
// filtro_conv3x3 -- 3x3 convolution engine for the image-filter processor.
//
// Reads a source image through the shared byte-addressed RAM port, applies
// one of four kernels with border replication, and writes the filtered
// image to a destination region. Each output pixel takes nine reads, one
// accumulate-only cycle and one write cycle.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   start             one-cycle frame request, only honoured when idle
//   mode              kernel: 0 copy, 1 gaussian, 2 sharpen, 3 laplacian
//   src_base/dst_base source and destination image base addresses
//   img_w/img_h       image dimensions in pixels
//   Data_in_RAM       RAM read data, valid the cycle after mem_RE_RAM
//   mem_RE_RAM        RAM read enable
//   mem_WE_RAM        RAM write enable
//   Data_Dir_RAM      RAM address (0 when the RAM is not accessed)
//   Data_RAM          RAM write data, holds the last written pixel
//   busy              high while a frame is in progress
//   done              one-cycle pulse when a frame completes
//   pix_count         pixels written in the current or last frame
module filtro_conv3x3 #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DIM_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [ADDR_W-1:0]  src_base,
  input  logic [ADDR_W-1:0]  dst_base,
  input  logic [DIM_W-1:0]   img_w,
  input  logic [DIM_W-1:0]   img_h,
  input  logic [PIX_W-1:0]   Data_in_RAM,
  output logic               mem_RE_RAM,
  output logic               mem_WE_RAM,
  output logic [ADDR_W-1:0]  Data_Dir_RAM,
  output logic [PIX_W-1:0]   Data_RAM,
  output logic               busy,
  output logic               done,
  output logic [2*DIM_W-1:0] pix_count
);

  // Five extra bits cover the largest kernel gain (16) plus a sign bit.
  localparam int ACC_W = PIX_W + 5;

  localparam logic signed [1:0] OFF_M1 = 2'b11;
  localparam logic signed [1:0] OFF_Z  = 2'b00;
  localparam logic signed [1:0] OFF_P1 = 2'b01;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ACC, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [3:0]               tap_q, tap_d;
  logic [DIM_W-1:0]         x_q, x_d, y_q, y_d;
  logic [DIM_W-1:0]         w_q, w_d, h_q, h_d;
  logic [1:0]               mode_q, mode_d;
  logic [ADDR_W-1:0]        src_q, src_d, dst_q, dst_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [PIX_W-1:0]         result_q, result_d;
  logic [2*DIM_W-1:0]       count_q, count_d;

  logic signed [1:0]        dxOff, dyOff;
  logic signed [DIM_W+1:0]  xs, ys, wS, hS;
  logic [DIM_W-1:0]         xc, yc;
  logic [2*DIM_W-1:0]       rdOff, wrOff;
  logic [ADDR_W-1:0]        rdAddr, wrAddr;
  logic [3:0]               coefIdx;
  logic signed [4:0]        coef;
  logic signed [ACC_W-1:0]  pixExt, coefExt, product, accSum, scaled, pixMax;
  logic [PIX_W-1:0]         satPix;
  logic                     lastPix;

  // Row-major kernel coefficients; idx 4 is the centre tap and odd
  // indices are the four edge-adjacent taps.
  function automatic logic signed [4:0] coefOf(input logic [1:0] m, input logic [3:0] idx);
    logic signed [4:0] c;
    c = 5'sd0;
    case (m)
      2'd0: c = (idx == 4'd4) ? 5'sd1 : 5'sd0;
      2'd1: begin
        if (idx == 4'd4)  c = 5'sd4;
        else if (idx[0])  c = 5'sd2;
        else              c = 5'sd1;
      end
      2'd2: begin
        if (idx == 4'd4)  c = 5'sd5;
        else if (idx[0])  c = -5'sd1;
        else              c = 5'sd0;
      end
      default: c = (idx == 4'd4) ? 5'sd8 : -5'sd1;
    endcase
    return c;
  endfunction

  // Neighbour offset of the current fetch tap, scanning rows top to bottom.
  always_comb begin
    dyOff = OFF_Z;
    dxOff = OFF_Z;
    case (tap_q)
      4'd0: begin dyOff = OFF_M1; dxOff = OFF_M1; end
      4'd1: begin dyOff = OFF_M1; dxOff = OFF_Z;  end
      4'd2: begin dyOff = OFF_M1; dxOff = OFF_P1; end
      4'd3: begin dyOff = OFF_Z;  dxOff = OFF_M1; end
      4'd4: begin dyOff = OFF_Z;  dxOff = OFF_Z;  end
      4'd5: begin dyOff = OFF_Z;  dxOff = OFF_P1; end
      4'd6: begin dyOff = OFF_P1; dxOff = OFF_M1; end
      4'd7: begin dyOff = OFF_P1; dxOff = OFF_Z;  end
      default: begin dyOff = OFF_P1; dxOff = OFF_P1; end
    endcase
  end

  // Clamp the neighbour coordinate into the image so border pixels are
  // replicated, then form the read and write addresses.
  always_comb begin
    wS = $signed({2'b00, w_q});
    hS = $signed({2'b00, h_q});
    xs = $signed({2'b00, x_q}) + {{DIM_W{dxOff[1]}}, dxOff};
    ys = $signed({2'b00, y_q}) + {{DIM_W{dyOff[1]}}, dyOff};
    if (xs[DIM_W+1])  xc = '0;
    else if (xs >= wS) xc = w_q - DIM_W'(1);
    else               xc = xs[DIM_W-1:0];
    if (ys[DIM_W+1])  yc = '0;
    else if (ys >= hS) yc = h_q - DIM_W'(1);
    else               yc = ys[DIM_W-1:0];
    rdOff  = {{DIM_W{1'b0}}, yc} * {{DIM_W{1'b0}}, w_q} + {{DIM_W{1'b0}}, xc};
    wrOff  = {{DIM_W{1'b0}}, y_q} * {{DIM_W{1'b0}}, w_q} + {{DIM_W{1'b0}}, x_q};
    rdAddr = src_q + ADDR_W'(rdOff);
    wrAddr = dst_q + ADDR_W'(wrOff);
    lastPix = (x_q == w_q - DIM_W'(1)) && (y_q == h_q - DIM_W'(1));
  end

  // Read data lags its request by a cycle, so the coefficient is the one of
  // the previous tap; in ACC it is the last tap's.
  always_comb begin
    coefIdx = (state_q == S_ACC) ? 4'd8 : tap_q - 4'd1;
    coef    = coefOf(mode_q, coefIdx);
    pixExt  = {5'b00000, Data_in_RAM};
    coefExt = {{PIX_W{coef[4]}}, coef};
    product = pixExt * coefExt;
    accSum  = acc_q + product;
    scaled  = (mode_q == 2'd1) ? (accSum >>> 4) : accSum;
    pixMax  = {5'b00000, {PIX_W{1'b1}}};
    if (scaled[ACC_W-1])     satPix = '0;
    else if (scaled > pixMax) satPix = '1;
    else                      satPix = scaled[PIX_W-1:0];
  end

  // Next-state and RAM-port decode.
  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    mode_d   = mode_q;
    src_d    = src_q;
    dst_d    = dst_q;
    acc_d    = acc_q;
    result_d = result_q;
    count_d  = count_q;
    mem_RE_RAM   = 1'b0;
    mem_WE_RAM   = 1'b0;
    Data_Dir_RAM = '0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode;
          src_d   = src_base;
          dst_d   = dst_base;
          w_d     = img_w;
          h_d     = img_h;
          x_d     = '0;
          y_d     = '0;
          tap_d   = '0;
          count_d = '0;
          state_d = (img_w == '0 || img_h == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        busy         = 1'b1;
        mem_RE_RAM   = 1'b1;
        Data_Dir_RAM = rdAddr;
        acc_d        = (tap_q == 4'd0) ? '0 : accSum;
        if (tap_q == 4'd8) begin
          tap_d   = '0;
          state_d = S_ACC;
        end else begin
          tap_d = tap_q + 4'd1;
        end
      end
      S_ACC: begin
        busy     = 1'b1;
        acc_d    = accSum;
        result_d = satPix;
        state_d  = S_WRITE;
      end
      S_WRITE: begin
        busy         = 1'b1;
        mem_WE_RAM   = 1'b1;
        Data_Dir_RAM = wrAddr;
        count_d      = count_q + (2*DIM_W)'(1);
        if (lastPix) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          if (x_q == w_q - DIM_W'(1)) begin
            x_d = '0;
            y_d = y_q + DIM_W'(1);
          end else begin
            x_d = x_q + DIM_W'(1);
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tap_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      w_q      <= '0;
      h_q      <= '0;
      mode_q   <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      acc_q    <= '0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      h_q      <= h_d;
      mode_q   <= mode_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      count_q  <= count_d;
    end
  end

  assign Data_RAM  = result_q;
  assign pix_count = count_q;

endmodule

// File: tb/tb_filtro_conv3x3.sv
// tb_filtro_conv3x3 -- bench for the 3x3 convolution engine: a byte RAM
// model serves reads and logs writes, known images are checked against
// tabulated results and random images against an arithmetic model.
module tb_filtro_conv3x3;

  localparam int PIX_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DIM_W  = 10;

  logic               clk;
  logic               rst;
  logic               start;
  logic [1:0]         mode;
  logic [ADDR_W-1:0]  src_base;
  logic [ADDR_W-1:0]  dst_base;
  logic [DIM_W-1:0]   img_w;
  logic [DIM_W-1:0]   img_h;
  logic [PIX_W-1:0]   Data_in_RAM;
  logic               mem_RE_RAM;
  logic               mem_WE_RAM;
  logic [ADDR_W-1:0]  Data_Dir_RAM;
  logic [PIX_W-1:0]   Data_RAM;
  logic               busy;
  logic               done;
  logic [2*DIM_W-1:0] pix_count;

  filtro_conv3x3 #(.PIX_W(PIX_W), .ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_base(src_base), .dst_base(dst_base), .img_w(img_w), .img_h(img_h),
    .Data_in_RAM(Data_in_RAM), .mem_RE_RAM(mem_RE_RAM), .mem_WE_RAM(mem_WE_RAM),
    .Data_Dir_RAM(Data_Dir_RAM), .Data_RAM(Data_RAM), .busy(busy), .done(done),
    .pix_count(pix_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: source bytes are preloaded by the stimulus, writes are logged.
  logic [7:0]  srcMem [0:4095];
  logic [7:0]  memRd;
  logic [31:0] wrAddrQ [$];
  logic [7:0]  wrDataQ [$];
  logic [31:0] rdAddrQ [$];
  int          overlapCnt;
  int          busyCnt;

  assign Data_in_RAM = memRd;

  // Sample the RAM port on each rising edge.
  always @(posedge clk) begin
    if (mem_RE_RAM) begin
      memRd <= srcMem[Data_Dir_RAM[11:0]];
      rdAddrQ.push_back(Data_Dir_RAM);
    end
    if (mem_WE_RAM) begin
      wrAddrQ.push_back(Data_Dir_RAM);
      wrDataQ.push_back(Data_RAM);
    end
    if (mem_RE_RAM && mem_WE_RAM) overlapCnt <= overlapCnt + 1;
    if (busy) busyCnt <= busyCnt + 1;
  end

  typedef struct packed {
    logic [1:0]  mode;
    logic [11:0] src;
    logic [11:0] dst;
    logic [3:0]  w;
    logic [3:0]  h;
    logic [71:0] pix;
    logic [71:0] expv;
  } vec_t;

  vec_t vecs [0:7];
  int   expQ [$];
  int   total;
  int   bad;
  int   kern [0:3][0:8] = '{
    '{ 0,  0,  0,  0, 1,  0,  0,  0,  0},
    '{ 1,  2,  1,  2, 4,  2,  1,  2,  1},
    '{ 0, -1,  0, -1, 5, -1,  0, -1,  0},
    '{-1, -1, -1, -1, 8, -1, -1, -1, -1}
  };

  function automatic int clampi(int v, int lo, int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Reference output pixel straight from the kernel definition.
  function automatic int refPixel(int m, int sb, int w, int h, int x, int y);
    int sum;
    int xc;
    int yc;
    sum = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        xc = clampi(x + dx, 0, w - 1);
        yc = clampi(y + dy, 0, h - 1);
        sum += kern[m][(dy + 1) * 3 + dx + 1] * int'(srcMem[(sb + yc * w + xc) & 32'hFFF]);
      end
    end
    if (m == 1) sum = sum >>> 4;
    if (sum < 0) return 0;
    if (sum > 255) return 255;
    return sum;
  endfunction

  task automatic checkValue(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start a frame and wait (bounded) for done; optionally pulse start and
  // scramble the configuration inputs while the frame runs.
  task automatic applyStimulus(input int m, input int sb, input int db, input int w,
                               input int h, input bit noisy, output int cyc);
    int maxc;
    maxc = 11 * w * h + 20;
    @(negedge clk);
    mode     = 2'(m);
    src_base = 32'(sb);
    dst_base = 32'(db);
    img_w    = 10'(w);
    img_h    = 10'(h);
    start    = 1'b1;
    cyc      = 0;
    for (int c = 1; c <= maxc; c++) begin
      @(posedge clk);
      #1;
      cyc   = c;
      start = 1'b0;
      if (done) break;
      if (noisy && busy && ($urandom_range(0, 3) == 0)) begin
        start    = 1'b1;
        mode     = 2'($urandom);
        src_base = $urandom;
        dst_base = $urandom;
        img_w    = 10'($urandom);
        img_h    = 10'($urandom);
      end
    end
    checkValue("doneSeen", longint'(done), 1);
    @(negedge clk);
  endtask

  task automatic checkOutput(input int sb, input int db, input int w, input int h,
                             input int wr0, input int rd0, input int cyc);
    int n;
    int p;
    int ea;
    n = w * h;
    checkValue("doneCycle", cyc, 11 * n + 1);
    checkValue("pixCount", longint'(pix_count), n);
    checkValue("writeCount", wrAddrQ.size() - wr0, n);
    checkValue("readCount", rdAddrQ.size() - rd0, 9 * n);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        p = y * w + x;
        if (wr0 + p < wrAddrQ.size()) begin
          checkValue($sformatf("wrAddr[%0d]", p), longint'(wrAddrQ[wr0 + p]), db + p);
          checkValue($sformatf("wrData[%0d]", p), longint'(wrDataQ[wr0 + p]), expQ[p]);
        end
        for (int k = 0; k < 9; k++) begin
          ea = sb + clampi(y + k / 3 - 1, 0, h - 1) * w + clampi(x + k % 3 - 1, 0, w - 1);
          if (rd0 + 9 * p + k < rdAddrQ.size())
            checkValue($sformatf("rdAddr[%0d.%0d]", p, k), longint'(rdAddrQ[rd0 + 9 * p + k]), ea);
        end
      end
    end
    if (n > 0) checkValue("dataHold", longint'(Data_RAM), expQ[n - 1]);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkValue({tag, ".re"}, longint'(mem_RE_RAM), 0);
    checkValue({tag, ".we"}, longint'(mem_WE_RAM), 0);
    checkValue({tag, ".addr"}, longint'(Data_Dir_RAM), 0);
    checkValue({tag, ".data"}, longint'(Data_RAM), 0);
    checkValue({tag, ".busy"}, longint'(busy), 0);
    checkValue({tag, ".done"}, longint'(done), 0);
    checkValue({tag, ".pixCount"}, longint'(pix_count), 0);
  endtask

  initial begin
    int cyc;
    int wr0;
    int rd0;
    int bz0;
    int ov0;
    int w;
    int h;
    int m;
    int sb;
    int db;
    int v;
    bit weSeen;
    logic [31:0] firstReads [0:8];

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    mode  = '0;
    src_base = '0;
    dst_base = '0;
    img_w = '0;
    img_h = '0;

    vecs[0] = '{mode:2'd1, src:12'h300, dst:12'h400, w:4'd3, h:4'd3,
                pix:{9{8'd100}}, expv:{9{8'd100}}};
    vecs[1] = '{mode:2'd2, src:12'h300, dst:12'h400, w:4'd3, h:4'd3,
                pix:{{4{8'd100}}, 8'd200, {4{8'd100}}},
                expv:{8'd100, 8'd0, 8'd100, 8'd0, 8'd255, 8'd0, 8'd100, 8'd0, 8'd100}};
    vecs[2] = '{mode:2'd3, src:12'h300, dst:12'h400, w:4'd3, h:4'd3,
                pix:{{4{8'd100}}, 8'd200, {4{8'd100}}},
                expv:{{4{8'd0}}, 8'd255, {4{8'd0}}}};
    vecs[3] = '{mode:2'd0, src:12'h100, dst:12'h200, w:4'd4, h:4'd2,
                pix:{8'd0, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0},
                expv:{8'd0, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0}};
    vecs[4] = '{mode:2'd0, src:12'h500, dst:12'h600, w:4'd1, h:4'd1,
                pix:{64'd0, 8'd37}, expv:{64'd0, 8'd37}};
    vecs[5] = '{mode:2'd1, src:12'h500, dst:12'h600, w:4'd1, h:4'd1,
                pix:{64'd0, 8'd37}, expv:{64'd0, 8'd37}};
    vecs[6] = '{mode:2'd2, src:12'h500, dst:12'h600, w:4'd1, h:4'd1,
                pix:{64'd0, 8'd37}, expv:{64'd0, 8'd37}};
    vecs[7] = '{mode:2'd3, src:12'h500, dst:12'h600, w:4'd1, h:4'd1,
                pix:{64'd0, 8'd37}, expv:{72'd0}};
    firstReads = '{32'h100, 32'h100, 32'h101, 32'h100, 32'h100, 32'h101,
                   32'h104, 32'h104, 32'h105};

    repeat (2) @(negedge clk);
    checkResetOutputs("reset");
    rst = 1'b0;
    ov0 = overlapCnt;

    $display("[TB] tabulated images");
    for (int i = 0; i < 8; i++) begin
      w = int'(vecs[i].w);
      h = int'(vecs[i].h);
      expQ.delete();
      for (int p = 0; p < w * h; p++) begin
        srcMem[int'(vecs[i].src) + p] = vecs[i].pix[p * 8 +: 8];
        expQ.push_back(int'(vecs[i].expv[p * 8 +: 8]));
      end
      wr0 = wrAddrQ.size();
      rd0 = rdAddrQ.size();
      applyStimulus(int'(vecs[i].mode), int'(vecs[i].src), int'(vecs[i].dst), w, h, 1'b0, cyc);
      checkOutput(int'(vecs[i].src), int'(vecs[i].dst), w, h, wr0, rd0, cyc);
      if (i == 3) begin
        for (int k = 0; k < 9; k++) begin
          if (rd0 + k < rdAddrQ.size())
            checkValue($sformatf("firstRead[%0d]", k), longint'(rdAddrQ[rd0 + k]), longint'(firstReads[k]));
        end
      end
    end

    $display("[TB] zero-dimension starts");
    for (int i = 0; i < 2; i++) begin
      wr0 = wrAddrQ.size();
      rd0 = rdAddrQ.size();
      bz0 = busyCnt;
      expQ.delete();
      applyStimulus(1, 12'h100, 12'h200, (i == 0) ? 0 : 2, (i == 0) ? 3 : 0, 1'b0, cyc);
      checkOutput(12'h100, 12'h200, 0, 0, wr0, rd0, cyc);
      checkValue("zeroDimBusy", busyCnt - bz0, 0);
    end

    $display("[TB] random images");
    for (int t = 0; t < 12; t++) begin
      w  = $urandom_range(1, 5);
      h  = $urandom_range(1, 5);
      m  = $urandom_range(0, 3);
      sb = $urandom_range(0, 12'h7E0);
      db = $urandom_range(12'h800, 12'hFE0);
      for (int p = 0; p < w * h; p++) begin
        if ($urandom_range(0, 3) == 0) v = ($urandom_range(0, 1) == 1) ? 255 : 0;
        else v = $urandom_range(0, 255);
        srcMem[sb + p] = 8'(v);
      end
      expQ.delete();
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          expQ.push_back(refPixel(m, sb, w, h, x, y));
      wr0 = wrAddrQ.size();
      rd0 = rdAddrQ.size();
      applyStimulus(m, sb, db, w, h, (t % 2) == 1, cyc);
      checkOutput(sb, db, w, h, wr0, rd0, cyc);
    end

    $display("[TB] reset during a write");
    for (int p = 0; p < 9; p++) srcMem[12'h700 + p] = 8'($urandom);
    @(negedge clk);
    mode     = 2'd1;
    src_base = 32'h700;
    dst_base = 32'h780;
    img_w    = 10'd3;
    img_h    = 10'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    weSeen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (mem_WE_RAM) begin
        weSeen = 1'b1;
        break;
      end
    end
    checkValue("writeBeforeReset", longint'(weSeen), 1);
    wr0 = wrAddrQ.size();
    rd0 = rdAddrQ.size();
    rst = 1'b1;
    #1;
    checkResetOutputs("midReset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("noWriteAfterReset", wrAddrQ.size() - wr0, 0);
    checkValue("noReadAfterReset", rdAddrQ.size() - rd0, 0);
    checkValue("idleAfterReset", longint'(busy), 0);

    expQ.delete();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 3; x++)
        expQ.push_back(refPixel(2, 12'h700, 3, 3, x, y));
    wr0 = wrAddrQ.size();
    rd0 = rdAddrQ.size();
    applyStimulus(2, 12'h700, 12'h780, 3, 3, 1'b1, cyc);
    checkOutput(12'h700, 12'h780, 3, 3, wr0, rd0, cyc);

    checkValue("reWeOverlap", overlapCnt - ov0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
